// File: rtl/spi_arb_pkg.sv
// Shared definitions for the two-master SPI bus arbiter: FSM encoding,
// master identifiers and the values the bus shows while nobody owns it.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AD  = 1'b1;

  localparam logic       IDLE_MOSI = 1'b0;
  localparam logic       IDLE_MISO = 1'b0;
  localparam logic [1:0] IDLE_NCS  = 2'b11;

  localparam int GUARD_W = 4;

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_arb_timer.sv
// Loadable up/down counter with a terminal-count flag; serves both the
// guard countdown and the bus-hold timeout.
module spi_arb_timer #(
  parameter int W    = 4,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= DOWN ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == term_val);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between the CPU SPI master and the A/D controller with
// round-robin grants, protected transactions, guard gaps and hold timeout.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int   GUARD_CYC = 2,
  parameter int   TIMEOUT   = 0,
  parameter int   TMO_W     = 16,
  parameter logic IDLE_SCLK = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       m0_req_i,
  output logic       m0_gnt_o,
  input  logic       m0_sclk_i,
  input  logic       m0_mosi_i,
  input  logic       m0_ncs_i,
  output logic       m0_miso_o,
  input  logic       m1_req_i,
  output logic       m1_gnt_o,
  input  logic       m1_sclk_i,
  input  logic       m1_mosi_i,
  input  logic       m1_ncs_i,
  output logic       m1_miso_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic [1:0] ncs_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYC - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] blocked_q, blocked_d, blocked_set;
  logic       busy_q, tmo_q, tmo_d;
  logic       guard_load, guard_tc, hold_load, hold_tc;
  logic [1:0] req, ncs_in, elig;
  logic       release_c;

  assign req       = {m1_req_i, m0_req_i};
  assign ncs_in    = {m1_ncs_i, m0_ncs_i};
  assign elig      = req & ~blocked_q;
  assign release_c = ~req[owner_q] & ncs_in[owner_q];

  spi_arb_timer #(.W(GUARD_W), .DOWN(1'b1)) u_guard (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load     (guard_load),
    .load_val (GUARD_LOAD),
    .en       (state_q == ST_GUARD),
    .term_val ('0),
    .tc       (guard_tc)
  );

  spi_arb_timer #(.W(TMO_W), .DOWN(1'b0)) u_hold (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load     (hold_load),
    .load_val ('0),
    .en       (state_q == ST_OWN),
    .term_val (TMO_LAST),
    .tc       (hold_tc)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    tmo_d       = 1'b0;
    guard_load  = 1'b0;
    hold_load   = 1'b0;
    blocked_set = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          owner_d   = (&elig) ? ~last_q : elig[M_AD];
          last_d    = owner_d;
          gnt_d     = onehot(owner_d);
          hold_load = 1'b1;
          state_d   = ST_OWN;
        end
      end
      ST_OWN: begin
        // Release wins over a timeout that lands in the same cycle.
        if (release_c) begin
          gnt_d      = 2'b00;
          guard_load = 1'b1;
          state_d    = ST_GUARD;
        end else if (TIMEOUT != 0 && hold_tc) begin
          gnt_d                = 2'b00;
          guard_load           = 1'b1;
          tmo_d                = 1'b1;
          blocked_set[owner_q] = 1'b1;
          state_d              = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_tc) state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
    blocked_d = (blocked_q | blocked_set) & req;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= M_CPU;
      last_q    <= M_AD;
      gnt_q     <= 2'b00;
      blocked_q <= 2'b00;
      busy_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      blocked_q <= blocked_d;
      busy_q    <= (state_d != ST_IDLE);
      tmo_q     <= tmo_d;
    end
  end

  // The registered grant selects the owner; its pins pass straight through.
  always_comb begin
    sclk_o    = IDLE_SCLK;
    mosi_o    = IDLE_MOSI;
    ncs_o     = IDLE_NCS;
    m0_miso_o = IDLE_MISO;
    m1_miso_o = IDLE_MISO;
    if (gnt_q[M_CPU]) begin
      sclk_o    = m0_sclk_i;
      mosi_o    = m0_mosi_i;
      ncs_o[0]  = m0_ncs_i;
      m0_miso_o = miso_i;
    end else if (gnt_q[M_AD]) begin
      sclk_o    = m1_sclk_i;
      mosi_o    = m1_mosi_i;
      ncs_o[1]  = m1_ncs_i;
      m1_miso_o = miso_i;
    end
  end

  assign m0_gnt_o  = gnt_q[M_CPU];
  assign m1_gnt_o  = gnt_q[M_AD];
  assign busy_o    = busy_q;
  assign timeout_o = tmo_q;

endmodule
